// File: rtl/upscale_tile_sequencer.sv
// Feeds column pairs into the 2x2->3x3 upscaler cell and emits the result as three tagged row beats.
// Optional resync statistics counter is enabled by defining UPSCALE_SEQ_STATS_EN.
module upscale_tile_sequencer #(
  parameter int SRC_COLS      = 640,
  parameter int SRC_ROW_PAIRS = 240,
  parameter int XY_W          = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [47:0]       s_data,
  input  logic              s_sof,
  output logic [95:0]       cell_original,
  input  logic [215:0]      cell_upscaled,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [71:0]       m_data,
  output logic [XY_W-1:0]   m_x,
  output logic [XY_W-1:0]   m_y,
  output logic              frame_done,
  output logic [15:0]       resync_count
);

  localparam int TILES  = SRC_COLS / 2;
  localparam int TILE_W = (TILES > 1) ? $clog2(TILES) : 1;
  localparam int PAIR_W = (SRC_ROW_PAIRS > 1) ? $clog2(SRC_ROW_PAIRS) : 1;

  typedef enum logic [2:0] {COL0, COL1, EMIT0, EMIT1, EMIT2} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [1:0][1:0][23:0]    r_window;
  logic [TILE_W-1:0]        r_tile;
  logic [PAIR_W-1:0]        r_pair;
  logic                     r_frame_done;

  logic                     w_load_c0;
  logic                     w_load_c1;
  logic                     w_clear_cnt;
  logic                     w_tile_adv;
  logic [1:0]               w_row;
  logic                     w_tile_last;
  logic                     w_pair_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COL0;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    s_ready      = 1'b0;
    m_valid      = 1'b0;
    w_load_c0    = 1'b0;
    w_load_c1    = 1'b0;
    w_clear_cnt  = 1'b0;
    w_tile_adv   = 1'b0;
    w_row        = 2'd0;
    case (r_state)
      COL0: begin
        s_ready = 1'b1;
        if (s_valid) begin
          w_load_c0    = 1'b1;
          w_clear_cnt  = s_sof;
          w_state_next = COL1;
        end
      end
      COL1: begin
        s_ready = 1'b1;
        // A start-of-frame here restarts the tile: this beat becomes column 0
        if (s_valid) begin
          if (s_sof) begin
            w_load_c0   = 1'b1;
            w_clear_cnt = 1'b1;
          end else begin
            w_load_c1    = 1'b1;
            w_state_next = EMIT0;
          end
        end
      end
      EMIT0: begin
        m_valid = 1'b1;
        w_row   = 2'd0;
        if (m_ready) w_state_next = EMIT1;
      end
      EMIT1: begin
        m_valid = 1'b1;
        w_row   = 2'd1;
        if (m_ready) w_state_next = EMIT2;
      end
      EMIT2: begin
        m_valid = 1'b1;
        w_row   = 2'd2;
        if (m_ready) begin
          w_tile_adv   = 1'b1;
          w_state_next = COL0;
        end
      end
      default: w_state_next = COL0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_window <= '0;
    end else begin
      if (w_load_c0) begin
        r_window[0][0] <= s_data[47:24];
        r_window[1][0] <= s_data[23:0];
      end
      if (w_load_c1) begin
        r_window[0][1] <= s_data[47:24];
        r_window[1][1] <= s_data[23:0];
      end
    end
  end

  assign w_tile_last = (r_tile == TILE_W'(TILES - 1));
  assign w_pair_last = (r_pair == PAIR_W'(SRC_ROW_PAIRS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tile       <= '0;
      r_pair       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_clear_cnt) begin
        r_tile <= '0;
        r_pair <= '0;
      end else if (w_tile_adv) begin
        if (w_tile_last) begin
          r_tile <= '0;
          if (w_pair_last) begin
            r_pair       <= '0;
            r_frame_done <= 1'b1;
          end else begin
            r_pair <= r_pair + PAIR_W'(1);
          end
        end else begin
          r_tile <= r_tile + TILE_W'(1);
        end
      end
    end
  end

`ifdef UPSCALE_SEQ_STATS_EN
  logic        w_resync;
  logic [15:0] r_resync_count;

  assign w_resync = (r_state == COL1) && s_valid && s_sof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resync_count <= 16'd0;
    end else if (w_resync && (r_resync_count != 16'hFFFF)) begin
      r_resync_count <= r_resync_count + 16'd1;
    end
  end

  assign resync_count = r_resync_count;
`else
  assign resync_count = 16'd0;
`endif

  assign cell_original = r_window;

  always_comb begin
    case (w_row)
      2'd0:    m_data = cell_upscaled[71:0];
      2'd1:    m_data = cell_upscaled[143:72];
      default: m_data = cell_upscaled[215:144];
    endcase
  end

  assign m_x        = XY_W'(r_tile) * XY_W'(3);
  assign m_y        = XY_W'(r_pair) * XY_W'(3) + XY_W'(w_row);
  assign frame_done = r_frame_done;

endmodule

// File: doc/upscale_tile_sequencer.md
# upscale_tile_sequencer

Sequences a column-pair pixel stream through the combinational `resolution_upscaler_cell`. It accepts two source columns (top and bottom pixel each) to form a 2x2 RGB window and drives that window into the cell. It then emits the 3x3 result as three output-row beats, each tagged with frame coordinates, for the frame-buffer writer. It sits between the line-pair reader and the frame-buffer writer.

## Interface
Parameters:
- SRC_COLS, 640, source columns per row; must be even. Tiles per row-pair = SRC_COLS/2.
- SRC_ROW_PAIRS, 240, source row pairs per frame.
- XY_W, 12, width of output coordinate ports.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input column valid
- s_ready  out  1  input column accepted when high with s_valid
- s_data  in  48  [47:24] top pixel, [23:0] bottom pixel (RGB, 8 b/channel)
- s_sof  in  1  beat is the first column of a frame
- cell_original  out  96  window to cell; [r][c] with r=0 top, c=0 left, 24 b/pixel
- cell_upscaled  in  216  cell result [R][C]; corners [2r][2c] equal original [r][c]
- m_valid  out  1  output row beat valid
- m_ready  in  1  downstream accepts
- m_data  out  72  three pixels of one output row, C=0 in [23:0]
- m_x  out  XY_W  output column of m_data[23:0] = tile*3
- m_y  out  XY_W  output row = pair*3 + R
- frame_done  out  1  one-cycle pulse after last beat of frame handshakes
- resync_count  out  16  saturating count of partial tiles discarded by s_sof

## Operation
- States: COL0, COL1, EMIT0, EMIT1, EMIT2. Reset state COL0.
- COL0: s_ready=1. On an accepted beat, load window column 0 (top into [0][0], bottom into [1][0]) and go to COL1.
- COL1: s_ready=1. On an accepted beat with s_sof=0, load column 1 and go to EMIT0.
- COL1 with s_sof=1 on an accepted beat: discard the held column and treat this beat as column 0 of a new frame. Stay in COL1, clear tile and pair counters, and increment resync_count.
- s_sof=1 accepted in COL0: clear tile and pair counters; the beat becomes column 0 of tile (0,0).
- EMITk (k=0..2): s_ready=0, m_valid=1, m_data=cell_upscaled[k], m_y=pair*3+k, m_x=tile*3. On m_ready, advance to EMITk+1; from EMIT2, go to COL0.
- The window register is stable throughout the EMIT states, so m_data remains stable while m_valid=1 and m_ready=0.
- At the EMIT2 handshake, increment the tile counter. If the tile counter was SRC_COLS/2-1, wrap it to 0 and increment the pair counter.
- If the pair counter was also SRC_ROW_PAIRS-1, wrap it to 0 and pulse frame_done in the next cycle.
- cell_original is always the window register; the block performs no arithmetic on pixel data.

## Timing
- Reset values: state=COL0, s_ready=1, m_valid=0, m_data follows the cell (window=0, so m_data=0), m_x=0, m_y=0, frame_done=0, resync_count=0, counters=0.
- Latency: column 1 is accepted at edge N; m_valid rises in cycle N+1.
- Minimum tile period is 5 cycles (2 in + 3 out). No input/output overlap.
- Reset asserted mid-tile or mid-emit aborts immediately and clears all state; the partial tile is never emitted.
- m_valid never deasserts without a handshake.
- Only the s_sof rule above restarts a tile; s_sof during EMIT is impossible because s_ready=0.

## Configuration
- UPSCALE_SEQ_STATS_EN defined: resync_count is implemented as described (16-bit, saturates at 0xFFFF, cleared only by reset).
- UPSCALE_SEQ_STATS_EN undefined: no counter logic; resync_count is tied to 0. Resync behaviour is otherwise identical.

## Test plan
- All-zero columns, m_ready=1 -> three beats with m_data=0, m_y=0,1,2, m_x=0, m_valid rising 1 cycle after column 1.
- All pixels (10,10,10) -> all nine output pixels (10,10,10).
- Column 0 top=(10,10,10), bottom=(0,0,10); column 1 both (10,10,10):
  - row 1 C1 = (7,7,10), C0 = (5,5,10);
  - row 2 = {C0 (0,0,10), C1 (5,5,10), C2 (10,10,10)}.
- m_ready low for 4 cycles in EMIT1 -> m_data, m_y held stable; s_ready stays 0; no beat lost or duplicated.
- SRC_COLS=4, SRC_ROW_PAIRS=2, 4 tiles streamed:
  - m_x sequence 0,3,0,3;
  - m_y bases 0,0,3,3;
  - single frame_done pulse after the last EMIT2 handshake, then counters wrap to 0.
- s_sof on the beat in COL1 -> partial tile dropped, resync_count=1 (0 without the macro), next emitted tile has m_x=0, m_y=0; rst_n pulsed during EMIT0 -> m_valid=0 and state COL0 on reset.
